wptr_full_ctrl: RTL and testbench

//  Write-side pointer and full-flag controller for the dual-clock SRAM FIFO; the write-domain peer of the read/empty logic.

---
 rtl/wptr_full_ctrl_if.sv | 26 ++
 rtl/wptr_full_ctrl.sv | 81 ++++++++
 tb/tb_wptr_full_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/wptr_full_ctrl_if.sv
// Write-side bundle of the dual-clock FIFO: client request, SRAM write port,
// read-pointer input and the status flags reported back to the client.
interface wptr_full_ctrl_if #(
    parameter int ADDRSIZE = 8
);
    logic                winc;
    logic [ADDRSIZE:0]   rptr;
    logic                wovf_clr;
    logic                wen;
    logic [ADDRSIZE-1:0] waddr;
    logic [ADDRSIZE:0]   wptr;
    logic                wfull;
    logic                walmost_full;
    logic [ADDRSIZE:0]   wlevel;
    logic                wovf;

    modport master (
        output winc, rptr, wovf_clr,
        input  wen, waddr, wptr, wfull, walmost_full, wlevel, wovf
    );

    modport slave (
        input  winc, rptr, wovf_clr,
        output wen, waddr, wptr, wfull, walmost_full, wlevel, wovf
    );
endinterface

// File: rtl/wptr_full_ctrl.sv
// Write pointer / full-flag controller: binary and Gray write pointers, rptr
// synchroniser into wclk, and registered full, almost-full, level and overflow.
module wptr_full_ctrl #(
    parameter int ADDRSIZE    = 8,
    parameter int SYNC_STAGES = 2,
    parameter int AF_THRESH   = 2**ADDRSIZE - 4
) (
    input  logic              wclk,
    input  logic              wrst,
    wptr_full_ctrl_if.slave   bus
);

    localparam logic [ADDRSIZE:0] AF_LIMIT = (ADDRSIZE+1)'(AF_THRESH);

    logic [ADDRSIZE:0] wbin;
    logic [ADDRSIZE:0] wptr_q;
    logic [ADDRSIZE:0] wbinnext;
    logic [ADDRSIZE:0] wgraynext;
    logic [ADDRSIZE:0] sync_q [SYNC_STAGES];
    logic [ADDRSIZE:0] wq_rptr;
    logic [ADDRSIZE:0] rbin_s;
    logic [ADDRSIZE:0] level_next;
    logic              full_next;
    logic              wfull_q;
    logic              walmost_full_q;
    logic [ADDRSIZE:0] wlevel_q;
    logic              wovf_q;

    assign bus.wen = bus.winc & ~wfull_q & ~wrst;

    assign wbinnext  = wbin + {{ADDRSIZE{1'b0}}, bus.wen};
    assign wgraynext = (wbinnext >> 1) ^ wbinnext;

    assign wq_rptr = sync_q[SYNC_STAGES-1];

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        rbin_s = '0;
        for (int i = 0; i <= ADDRSIZE; i++) begin
            rbin_s[i] = ^(wq_rptr >> i);
        end
    end

    assign level_next = wbinnext - rbin_s;
    assign full_next  = (wgraynext == {~wq_rptr[ADDRSIZE:ADDRSIZE-1],
                                       wq_rptr[ADDRSIZE-2:0]});

    always_ff @(posedge wclk) begin
        if (wrst) begin
            wbin           <= '0;
            wptr_q         <= '0;
            wfull_q        <= 1'b0;
            walmost_full_q <= 1'b0;
            wlevel_q       <= '0;
            wovf_q         <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            wbin           <= wbinnext;
            wptr_q         <= wgraynext;
            wfull_q        <= full_next;
            walmost_full_q <= (level_next >= AF_LIMIT);
            wlevel_q       <= level_next;
            // A new overflow in the same cycle as a clear must not be lost.
            wovf_q         <= (bus.winc & wfull_q) | (wovf_q & ~bus.wovf_clr);
            sync_q[0]      <= bus.rptr;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign bus.waddr        = wbin[ADDRSIZE-1:0];
    assign bus.wptr         = wptr_q;
    assign bus.wfull        = wfull_q;
    assign bus.walmost_full = walmost_full_q;
    assign bus.wlevel       = wlevel_q;
    assign bus.wovf         = wovf_q;

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Bench for wptr_full_ctrl (ADDRSIZE=3): directed scenarios followed by random
// traffic, all checked against a count-based occupancy model.
module tb_wptr_full_ctrl;

    logic wclk = 1'b0;
    logic wrst = 1'b1;

    always #5 wclk = ~wclk;

    wptr_full_ctrl_if #(.ADDRSIZE(3)) bus ();

    wptr_full_ctrl #(
        .ADDRSIZE(3),
        .SYNC_STAGES(2),
        .AF_THRESH(6)
    ) dut (
        .wclk(wclk),
        .wrst(wrst),
        .bus (bus.slave)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Model: counts of writes accepted and reads seen, mod 16, plus the two
    // edges of delay the read count takes to reach the write side.
    int m_wr, m_full, m_lvl, m_af, m_ovf, s0, s1;
    int rd_cnt;

    function automatic int gray4(input int b);
        return (b ^ (b >> 1)) & 15;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input bit rst, input bit inc, input bit clr);
        int acc, occ;
        wrst         = rst;
        bus.winc     = inc;
        bus.wovf_clr = clr;
        bus.rptr     = 4'(gray4(rd_cnt));
        #1;
        chk("wen", int'(bus.wen), int'(!rst && inc && (m_full == 0)));
        @(posedge wclk);
        if (rst) begin
            m_wr = 0; m_full = 0; m_lvl = 0; m_af = 0; m_ovf = 0; s0 = 0; s1 = 0;
        end else begin
            acc    = (inc && m_full == 0) ? 1 : 0;
            m_ovf  = ((inc && m_full != 0) || (m_ovf != 0 && !clr)) ? 1 : 0;
            m_wr   = (m_wr + acc) & 15;
            occ    = (m_wr - s1) & 15;
            m_full = (occ == 8) ? 1 : 0;
            m_lvl  = occ;
            m_af   = (occ >= 6) ? 1 : 0;
            s1     = s0;
            s0     = rd_cnt & 15;
        end
        #1;
        chk("wptr",         int'(bus.wptr),         gray4(m_wr));
        chk("waddr",        int'(bus.waddr),        m_wr & 7);
        chk("wfull",        int'(bus.wfull),        m_full);
        chk("walmost_full", int'(bus.walmost_full), m_af);
        chk("wlevel",       int'(bus.wlevel),       m_lvl);
        chk("wovf",         int'(bus.wovf),         m_ovf);
    endtask

    initial begin
        int total;
        bus.winc     = 1'b0;
        bus.wovf_clr = 1'b0;
        bus.rptr     = '0;
        m_wr = 0; m_full = 0; m_lvl = 0; m_af = 0; m_ovf = 0; s0 = 0; s1 = 0;
        rd_cnt = 0;
        @(posedge wclk);
        #1;

        // Reset and fill: eight writes with no reads.
        step(1, 0, 0);
        step(1, 1, 0);
        chk("rst_wptr",  int'(bus.wptr),  0);
        chk("rst_wlevel", int'(bus.wlevel), 0);
        for (int i = 0; i < 8; i++) begin
            chk("t1_waddr_pre", int'(bus.waddr), i);
            step(0, 1, 0);
            if (i == 4) chk("t2_af_low", int'(bus.walmost_full), 0);
            if (i == 5) begin
                chk("t2_af_high", int'(bus.walmost_full), 1);
                chk("t2_level6",  int'(bus.wlevel), 6);
            end
        end
        chk("t1_wptr_full", int'(bus.wptr),   4'b1100);
        chk("t1_wfull",     int'(bus.wfull),  1);
        chk("t1_wlevel",    int'(bus.wlevel), 8);

        // Writes while full: blocked, overflow sticky, set wins over clear.
        step(0, 1, 0);
        chk("t3_wovf_set", int'(bus.wovf), 1);
        chk("t3_wptr_hold", int'(bus.wptr), 4'b1100);
        step(0, 1, 0);
        step(0, 1, 1);
        chk("t3_set_wins", int'(bus.wovf), 1);
        step(0, 0, 1);
        chk("t3_clr", int'(bus.wovf), 0);

        // Three reads: full drops only after the pointer crosses the synchroniser.
        rd_cnt = 3;
        step(0, 0, 0);
        chk("t4_full_e1", int'(bus.wfull), 1);
        step(0, 0, 0);
        chk("t4_full_e2", int'(bus.wfull), 1);
        step(0, 0, 0);
        chk("t4_full_e3", int'(bus.wfull), 0);
        chk("t4_level",   int'(bus.wlevel), 5);

        // Wrap: 20 writes with reads trailing by three entries.
        rd_cnt = 0;
        step(1, 0, 0);
        total = 0;
        for (int i = 0; i < 20; i++) begin
            rd_cnt = (total >= 3) ? ((total - 3) & 15) : 0;
            step(0, 1, 0);
            total++;
            if (total == 15) chk("t5_wptr_b15", int'(bus.wptr), 4'b1000);
            if (total == 16) begin
                chk("t5_wptr_b16", int'(bus.wptr),  4'b0000);
                chk("t5_waddr",    int'(bus.waddr), 0);
            end
            chk("t5_no_full", int'(bus.wfull), 0);
        end

        // Reset mid-operation with a write pending.
        rd_cnt = 0;
        step(1, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 0);
        chk("t6_level5", int'(bus.wlevel), 5);
        step(1, 1, 0);
        chk("t6_rst_level", int'(bus.wlevel), 0);
        chk("t6_rst_waddr", int'(bus.waddr),  0);
        step(0, 1, 0);
        chk("t6_first_write", int'(bus.waddr), 1);

        // Random traffic with legal reads (never ahead of accepted writes).
        for (int i = 0; i < 600; i++) begin
            bit r, w, c;
            r = ($urandom_range(0, 99) < 2);
            w = ($urandom_range(0, 99) < 70);
            c = ($urandom_range(0, 99) < 10);
            if (r) begin
                rd_cnt = 0;
            end else if (((m_wr - rd_cnt) & 15) != 0 && $urandom_range(0, 99) < 55) begin
                rd_cnt = (rd_cnt + 1) & 15;
            end
            step(r, w, c);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
